// File: rtl/nmea_pkg.sv
// Shared types and constants for the NMEA receive path (UART receiver and sentence parser).
package nmea_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  localparam int DEFAULT_CLK_HZ = 100_000_000;
  localparam int DEFAULT_BAUD   = 9600;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/nmea_baud_tick.sv
// Sample-tick divider: one-clk tick every DIV clocks, phase re-aligned by a synchronous clear.
module nmea_baud_tick
  import nmea_pkg::*;
#(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nmea_uart_rx.sv
// 8N1 oversampling UART receiver feeding the NMEA parser with char/valid.
// Define NMEA_RX_MAJORITY_EN for a 3-sample mid-bit majority vote instead of a single sample.
module nmea_uart_rx
  import nmea_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] char,
  output logic       valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  // samp_cnt holds the tick count already seen in this bit; the decision tick is the one
  // that brings it to the mid-bit point (one tick later when voting).
`ifdef NMEA_RX_MAJORITY_EN
  localparam logic [SW-1:0] DEC_PRE = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] DEC_PRE = SW'(OVERSAMPLE / 2 - 1);
`endif

  logic rx_m, rx_s;
  rx_state_t state;
  logic [SW-1:0] samp_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic tick, decide, bit_end, sample, div_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef NMEA_RX_MAJORITY_EN
  logic [1:0] vote_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_sr <= 2'b11;
    end else if (tick) begin
      vote_sr <= {vote_sr[0], rx_s};
    end
  end

  assign sample = majority3(vote_sr[1], vote_sr[0], rx_s);
`else
  assign sample = rx_s;
`endif

  assign decide  = tick && (samp_cnt == DEC_PRE);
  assign bit_end = tick && (samp_cnt == LAST);

  // Re-phase the divider on the start edge; in BREAK it measures how long the line has stayed high.
  assign div_clear = ((state == IDLE) && !rx_s)
                   || ((state == STOP) && decide && !sample)
                   || ((state == BREAK) && !rx_s);

  nmea_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (div_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      samp_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      char        <= 8'h00;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid       <= 1'b0;
      framing_err <= 1'b0;
      if (tick) begin
        samp_cnt <= (samp_cnt == LAST) ? '0 : samp_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            samp_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (decide && sample) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (decide) begin
            shreg <= {sample, shreg[7:1]};
          end
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        // Leaving mid stop bit keeps the following start edge visible for back-to-back frames.
        STOP: begin
          if (decide) begin
            if (sample) begin
              char  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          if (tick && rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmea_uart_rx.sv
// Scoreboard bench for nmea_uart_rx: frames are driven bit by bit, expected bytes queued, a monitor checks each valid.
module tb_nmea_uart_rx;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int DIV      = CLK_HZ / (BAUD * OS);
  localparam int BIT_CLKS = DIV * OS;
`ifdef NMEA_RX_MAJORITY_EN
  localparam int LAT_NOM = 1530;
`else
  localparam int LAT_NOM = 1520;
`endif

  logic clk, rst, rx;
  logic [7:0] char;
  logic valid, framing_err, busy;

  nmea_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .char        (char),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;
  longint cycle = 0;
  longint last_valid_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_char = 8'h00;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: a byte is recovered from its data bits; a single-sample receiver sees a mid-bit high glitch.
  function automatic logic [7:0] expected_byte(input logic [7:0] data, input int glitch_bit);
    logic [7:0] r;
    r = data;
`ifndef NMEA_RX_MAJORITY_EN
    if (glitch_bit >= 0) r[glitch_bit] = 1'b1;
`endif
    return r;
  endfunction

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    model_char = b;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; glitch_frame_bit forces a one-tick high pulse at mid-bit, abort_at stops early.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int glitch_frame_bit, input int abort_at);
    logic [9:0] frame;
    int n;
    frame = {stop_bit, data, 1'b0};
    n = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (n == abort_at) return;
        rx = frame[b];
        if (b == glitch_frame_bit && c >= BIT_CLKS / 2 - DIV / 2 && c < BIT_CLKS / 2 + DIV / 2) rx = 1'b1;
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid || framing_err) checkOutput("valid_ferr_exclusive", {31'd0, valid & framing_err}, 0);
      if (valid) begin
        last_valid_cyc = cycle;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got char 0x%0h, expected no valid", char);
        end else begin
          checkOutput("char", {24'd0, char}, {24'd0, exp_q.pop_front()});
        end
      end
      if (framing_err) ferr_seen++;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] stream [14] = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C,
                              8'h31, 8'h32, 8'h33, 8'h35, 8'h31, 8'h39, 8'h2C};

  initial begin
    int ferr0;
    longint t0, lat;
    logic [7:0] rb;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_char", {24'd0, char}, 0);
    checkOutput("rst_valid", {31'd0, valid}, 0);
    checkOutput("rst_ferr", {31'd0, framing_err}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    idle(50);

    $display("[TB] single byte 0x24");
    ferr0 = ferr_seen;
    expect_byte(8'h24);
    t0 = cycle;
    applyStimulus(8'h24, 1'b1, -1, -1);
    idle(20);
    wait_drain("single_drain");
    lat = last_valid_cyc - t0;
    $display("[TB] latency %0d clks", lat);
    checkOutput("latency_window", {31'd0, (lat >= LAT_NOM - 12) && (lat <= LAT_NOM + 12)}, 1);
    checkOutput("single_no_ferr", ferr_seen - ferr0, 0);

    $display("[TB] back-to-back NMEA stream");
    ferr0 = ferr_seen;
    for (int i = 0; i < 14; i++) begin
      expect_byte(stream[i]);
      applyStimulus(stream[i], 1'b1, -1, -1);
    end
    idle(20);
    wait_drain("stream_drain");
    checkOutput("stream_no_ferr", ferr_seen - ferr0, 0);

    $display("[TB] random bytes with random gaps");
    ferr0 = ferr_seen;
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      expect_byte(rb);
      applyStimulus(rb, 1'b1, -1, -1);
      idle($urandom_range(0, 200));
    end
    idle(20);
    wait_drain("random_drain");
    checkOutput("random_no_ferr", ferr_seen - ferr0, 0);

    $display("[TB] start glitch");
    rx = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_high", {31'd0, busy}, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (55) @(negedge clk);
    checkOutput("glitch_busy_low", {31'd0, busy}, 0);
    idle(100);
    expect_byte(8'h41);
    applyStimulus(8'h41, 1'b1, -1, -1);
    idle(20);
    wait_drain("after_glitch_drain");

    $display("[TB] framing error and line break");
    ferr0 = ferr_seen;
    applyStimulus(8'h55, 1'b0, -1, -1);
    rx = 1'b0;
    repeat (3200) @(negedge clk);
    idle(100);
    checkOutput("break_one_ferr", ferr_seen - ferr0, 1);
    checkOutput("break_char_kept", {24'd0, char}, {24'd0, model_char});
    expect_byte(8'h2C);
    applyStimulus(8'h2C, 1'b1, -1, -1);
    idle(20);
    wait_drain("after_break_drain");

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5, 1'b1, -1, 5 * BIT_CLKS + BIT_CLKS / 2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_char = 8'h00;
    @(negedge clk);
    checkOutput("midrst_char", {24'd0, char}, {24'd0, model_char});
    checkOutput("midrst_valid", {31'd0, valid}, 0);
    checkOutput("midrst_busy", {31'd0, busy}, 0);
    idle(100);
    expect_byte(8'h33);
    applyStimulus(8'h33, 1'b1, -1, -1);
    idle(20);
    wait_drain("after_rst_drain");

    $display("[TB] mid-bit glitch on data bit 3");
    expect_byte(expected_byte(8'h00, 3));
    applyStimulus(8'h00, 1'b1, 4, -1);
    idle(20);
    wait_drain("midbit_drain");
    checkOutput("final_char", {24'd0, char}, {24'd0, model_char});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
